// File: rtl/four_bit_adder.sv
// Registered ripple-carry adder: WIDTH full-adder cells feeding an output register.
// Define FOUR_BIT_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module four_bit_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef FOUR_BIT_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             valid_q;

  // Explicit per-bit full-adder cells; carry[i] feeds cell i.
  always_comb begin
    carry    = '0;
    sum_d    = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_d[i]   = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end
    cout_d = carry[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= 1'b1;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

`ifdef FOUR_BIT_ADDER_OVF_EN
  logic ovf_d, ovf_q;

  // Carry into and out of the MSB disagree exactly on two's-complement overflow.
  always_comb begin
    ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_four_bit_adder.sv
// Self-checking bench for four_bit_adder: arithmetic reference model plus directed literals.
// Exercises the ovf output as well when FOUR_BIT_ADDER_OVF_EN is defined.
module tb_four_bit_adder;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] a_in, b_in;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;
  logic         ovf_o;

  int errors = 0;
  int checks = 0;

  four_bit_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a_in),
    .B         (b_in),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef FOUR_BIT_ADDER_OVF_EN
    ,
    .ovf       (ovf_o)
`endif
  );

`ifndef FOUR_BIT_ADDER_OVF_EN
  assign ovf_o = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the values sampled at each edge.
  int exp_total;
  bit exp_valid;
  bit exp_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_total <= 0;
      exp_ovf   <= 1'b0;
    end else begin
      int sa, sb, ss;
      sa = (a_in >= 8) ? int'(a_in) - 16 : int'(a_in);
      sb = (b_in >= 8) ? int'(b_in) - 16 : int'(b_in);
      ss = sa + sb + int'(cin);
      exp_valid <= 1'b1;
      exp_total <= int'(a_in) + int'(b_in) + int'(cin);
      exp_ovf   <= (ss > 7) || (ss < -8);
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("sum", {28'd0, sum}, exp_total % 16);
      check("cout", {31'd0, cout}, (exp_total >= 16) ? 32'd1 : 32'd0);
`ifdef FOUR_BIT_ADDER_OVF_EN
      check("ovf", {31'd0, ovf_o}, {31'd0, exp_ovf});
`endif
    end else begin
      check("sum_rst", {28'd0, sum}, 32'd0);
      check("cout_rst", {31'd0, cout}, 32'd0);
    end
  end

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    #1;
    a_in = a;
    b_in = b;
    cin  = c;
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] s, input logic co);
    @(posedge clk);
    #1;
    check({name, "_sum"}, {28'd0, sum}, {28'd0, s});
    check({name, "_cout"}, {31'd0, cout}, {31'd0, co});
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    a_in = W'($urandom);
    b_in = W'($urandom);
    cin  = 1'($urandom);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_sum", {28'd0, sum}, 32'd0);
    check("rst_async_cout", {31'd0, cout}, 32'd0);
    check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_valid", {31'd0, out_valid}, 32'd1);

    apply(4'h3, 4'h5, 1'b0);
    expect_out("add_3_5", 4'h8, 1'b0);
    apply(4'hF, 4'h1, 1'b0);
    expect_out("wrap_F_1", 4'h0, 1'b1);
    apply(4'hF, 4'hF, 1'b1);
    expect_out("max_F_F_1", 4'hF, 1'b1);

    // Five random pairs, cin=0, checked by the model each cycle.
    for (int i = 0; i < 5; i++) apply(W'($urandom), W'($urandom), 1'b0);

`ifdef FOUR_BIT_ADDER_OVF_EN
    apply(4'h7, 4'h1, 1'b0);
    expect_out("ovf_7_1", 4'h8, 1'b0);
    check("ovf_7_1_flag", {31'd0, ovf_o}, 32'd1);
    apply(4'h8, 4'h8, 1'b0);
    expect_out("ovf_8_8", 4'h0, 1'b1);
    check("ovf_8_8_flag", {31'd0, ovf_o}, 32'd1);
    apply(4'hF, 4'h1, 1'b0);
    expect_out("ovf_F_1", 4'h0, 1'b1);
    check("ovf_F_1_flag", {31'd0, ovf_o}, 32'd0);
`endif

    // Reset between edges discards the pending 9+9 result.
    apply(4'h9, 4'h9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_sum", {28'd0, sum}, 32'd0);
    check("mid_rst_cout", {31'd0, cout}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_no_result_sum", {28'd0, sum}, 32'd0);
    check("mid_rst_no_result_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    expect_out("post_rst_9_9", 4'h2, 1'b1);

    // Randomized soak including cin.
    for (int i = 0; i < 200; i++) apply(W'($urandom), W'($urandom), 1'($urandom));
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/four_bit_adder.md
Name: four_bit_adder

Overview:
- Registered 4-bit binary adder with carry-in and carry-out.
- Combinational ripple-carry chain of WIDTH full-adder cells, followed by an output register.
- Used as a small arithmetic leaf cell wherever a clocked add with a carry chain is needed.
- One clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 4, operand and sum width in bits. Only 4 is verified; the ripple structure must still elaborate for any WIDTH >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  unsigned operand A.
- B  input  WIDTH  unsigned operand B.
- cin  input  1  carry-in into bit 0.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  registered carry-out of the MSB cell.
- out_valid  output  1  high once sum/cout hold a result computed since reset release.
- ovf  output  1  registered signed-overflow flag; exists only with FOUR_BIT_ADDER_OVF_EN.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Combinational path:
  - Explicit chain of WIDTH full-adder cells.
  - Cell i computes s[i] = A[i]^B[i]^c[i] and c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i]).
  - c[0] = cin.
  - Result satisfies {c[WIDTH], s} = A + B + cin, exactly.
- Register stage:
  - On every rising clk edge with rst_n high: sum <= s, cout <= c[WIDTH], out_valid <= 1.
  - There is no enable and no input handshake; inputs are sampled every cycle.
- Latency: exactly 1 clk cycle from inputs to outputs. Outputs stay stable between edges regardless of input glitches.
- Reset:
  - rst_n low forces sum=0, cout=0, out_valid=0 (and ovf=0) immediately, without waiting for clk.
  - Outputs hold those values while rst_n is low.
  - First result appears on the first rising edge after rst_n deasserts.
- Reset mid-operation: an in-flight result is discarded; out_valid drops to 0 asynchronously.
- Wrap-around: the sum is modulo 2^WIDTH and the carry is reported only via cout. For example, F+1+0 gives sum=0, cout=1.
- Maximum case: F+F+1 gives sum=F, cout=1.
- Unknown/undriven inputs: no requirement on the output value, but the X must not persist past the next edge with known inputs.

Optional Feature:
- Macro: FOUR_BIT_ADDER_OVF_EN.
- When defined:
  - Port ovf is present.
  - ovf <= c[WIDTH] ^ c[WIDTH-1], registered with the same 1-cycle latency and reset to 0.
  - This flags two's-complement overflow when A and B are treated as signed.
- When undefined:
  - Port ovf and its register are absent.
  - All other behaviour is identical.

Test Plan:
- rst_n=0 with random A/B -> sum=0, cout=0, out_valid=0 immediately. Release rst_n -> out_valid=1 after the first edge.
- A=3, B=5, cin=0 -> after one edge, sum=8, cout=0.
- A=F, B=1, cin=0 -> sum=0, cout=1. Then A=F, B=F, cin=1 -> sum=F, cout=1.
- Five random {A,B} pairs at 10 ns spacing, cin=0 -> each edge matches (A+B) mod 16 and carry against a behavioural model, with 1-cycle lag.
- Drive A=9, B=9, then pull rst_n low between edges -> outputs clear asynchronously and the pending 2/cout=1 result never appears.
- With FOUR_BIT_ADDER_OVF_EN:
  - A=7, B=1 -> ovf=1, sum=8.
  - A=8, B=8 -> ovf=1, sum=0, cout=1.
  - A=F, B=1 -> ovf=0.
